// File: rtl/i2c_segment_target_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : i2c_seg_pkg                                                  |
// | Purpose   : Shared types and constants for the I2C segment target:       |
// |             FSM state encoding, R/W bit values and the byte width.       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package i2c_seg_pkg;

   localparam int   BYTE_BITS    = 8;
   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WRITE_ACK = 3'd4,
      ST_READ      = 3'd5,
      ST_READ_ACK  = 3'd6
   } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_segment_target_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : i2c_segment_target_if                                        |
// | Purpose   : Bundles the I2C pins and the segment-side outputs.           |
// | Signals   : scl_in, sda_in  - raw (async) I2C lines into the target      |
// |             sda_oe          - 1 = target pulls SDA low                   |
// |             seg_out[7:0]    - latched segment pattern (bit0 = seg a)     |
// |             wr_strobe       - 1-cycle pulse when seg_out is updated      |
// |             busy            - transaction in progress                    |
// | Modports  : slave (the target), master (bus / environment side)          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface i2c_segment_target_if;
   import i2c_seg_pkg::*;

   logic                 scl_in;
   logic                 sda_in;
   logic                 sda_oe;
   logic [BYTE_BITS-1:0] seg_out;
   logic                 wr_strobe;
   logic                 busy;

   modport slave  (input  scl_in, sda_in,
                   output sda_oe, seg_out, wr_strobe, busy);
   modport master (output scl_in, sda_in,
                   input  sda_oe, seg_out, wr_strobe, busy);
endinterface
`default_nettype wire

// File: rtl/i2c_segment_target_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : i2c_sync_edge                                                |
// | Purpose   : Multi-flop synchroniser for one async line plus edge detect. |
// | Ports     : clk, rst      - clock / synchronous active-high reset        |
// |             din           - asynchronous input                           |
// |             level         - synchronised level                           |
// |             rise, fall    - single-cycle edge pulses on level            |
// | Params    : SYNC_STAGES   - synchroniser depth (>= 2)                    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic din,
   output logic      level,
   output logic      rise,
   output logic      fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // Reset to 1 (idle bus level) so leaving reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule
`default_nettype wire

// File: rtl/i2c_segment_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : i2c_segment_target                                           |
// | Purpose   : I2C target receiver feeding the 7-segment stage. Write bytes |
// |             addressed to ADDR are latched into seg_out (last wins).      |
// | Ports     : clk, rst - clock / synchronous active-high reset             |
// |             bus      - i2c_segment_target_if.slave (scl_in, sda_in,      |
// |                        sda_oe, seg_out, wr_strobe, busy)                 |
// | Params    : ADDR, SYNC_STAGES, RESET_PATTERN                             |
// | Config    : I2C_SEG_READBACK_EN - when defined, a read of ADDR returns   |
// |             seg_out; otherwise reads are NACKed like a wrong address.    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_segment_target
   import i2c_seg_pkg::*;
#(
   parameter logic [6:0]           ADDR          = 7'h2A,
   parameter int                   SYNC_STAGES   = 2,
   parameter logic [BYTE_BITS-1:0] RESET_PATTERN = 8'h00
) (
   input wire logic             clk,
   input wire logic             rst,
   i2c_segment_target_if.slave  bus
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst(rst), .din(bus.scl_in),
      .level(scl), .rise(scl_rise), .fall(scl_fall));

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst(rst), .din(bus.sda_in),
      .level(sda), .rise(sda_rise), .fall(sda_fall));

   // Bus conditions: SDA edges only count as START/STOP while SCL is high.
   logic start_cond, stop_cond;
   assign start_cond = sda_fall & scl;
   assign stop_cond  = sda_rise & scl;

   seg_state_t           state;
   logic [2:0]           bit_cnt;
   logic [BYTE_BITS-2:0] shift;   // first 7 bits of a byte; 8th comes straight from sda
   logic [BYTE_BITS-1:0] seg_reg;
   logic                 sda_drive;
   logic                 strobe;
   logic                 busy_reg;
`ifdef I2C_SEG_READBACK_EN
   logic                 rd_mode;
   logic [BYTE_BITS-1:0] tx;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         shift     <= '0;
         seg_reg   <= RESET_PATTERN;
         sda_drive <= 1'b0;
         strobe    <= 1'b0;
         busy_reg  <= 1'b0;
`ifdef I2C_SEG_READBACK_EN
         rd_mode   <= 1'b0;
         tx        <= '0;
`endif
      end else begin
         strobe <= 1'b0;
         if (start_cond) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            sda_drive <= 1'b0;
            busy_reg  <= 1'b1;
         end else if (stop_cond) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            sda_drive <= 1'b0;
            busy_reg  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift   <= {shift[BYTE_BITS-3:0], sda};
                     bit_cnt <= bit_cnt + 3'd1;   // 7 -> 0 wrap entering ACK
                     if (bit_cnt == 3'(BYTE_BITS-1)) begin
                        // shift now holds the 7 address bits, sda is R/W
                        if (shift == ADDR && sda == I2C_RW_WRITE) begin
                           state <= ST_ADDR_ACK;
`ifdef I2C_SEG_READBACK_EN
                           rd_mode <= 1'b0;
                        end else if (shift == ADDR && sda == I2C_RW_READ) begin
                           state   <= ST_ADDR_ACK;
                           rd_mode <= 1'b1;
`endif
                        end else begin
                           state    <= ST_IDLE;
                           busy_reg <= 1'b0;
                        end
                     end
                  end
               end
               // First SCL fall after bit 8 asserts ACK, the next one releases.
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_drive) begin
                        sda_drive <= 1'b1;
                     end else begin
`ifdef I2C_SEG_READBACK_EN
                        if (rd_mode) begin
                           // Release ACK and present the MSB on the same fall.
                           sda_drive <= ~seg_reg[BYTE_BITS-1];
                           tx        <= {seg_reg[BYTE_BITS-2:0], 1'b0};
                           state     <= ST_READ;
                        end else begin
                           sda_drive <= 1'b0;
                           state     <= ST_WRITE;
                        end
`else
                        sda_drive <= 1'b0;
                        state     <= ST_WRITE;
`endif
                     end
                  end
               end
               ST_WRITE: begin
                  if (scl_rise) begin
                     shift   <= {shift[BYTE_BITS-3:0], sda};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'(BYTE_BITS-1)) begin
                        seg_reg <= {shift, sda};
                        strobe  <= 1'b1;
                        state   <= ST_WRITE_ACK;
                     end
                  end
               end
               ST_WRITE_ACK: begin
                  if (scl_fall) begin
                     if (!sda_drive) begin
                        sda_drive <= 1'b1;
                     end else begin
                        sda_drive <= 1'b0;
                        state     <= ST_WRITE;
                     end
                  end
               end
`ifdef I2C_SEG_READBACK_EN
               ST_READ: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'(BYTE_BITS-1))
                        state <= ST_READ_ACK;
                  end else if (scl_fall) begin
                     sda_drive <= ~tx[BYTE_BITS-1];
                     tx        <= {tx[BYTE_BITS-2:0], 1'b0};
                  end
               end
               // Falls here just keep SDA released for the master's ACK bit.
               ST_READ_ACK: begin
                  if (scl_fall) begin
                     sda_drive <= 1'b0;
                  end else if (scl_rise) begin
                     if (sda) begin
                        state    <= ST_IDLE;
                        busy_reg <= 1'b0;
                     end else begin
                        tx    <= seg_reg;
                        state <= ST_READ;
                     end
                  end
               end
`endif
               default: begin
                  state     <= ST_IDLE;
                  sda_drive <= 1'b0;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sda_oe    = sda_drive;
   assign bus.seg_out   = seg_reg;
   assign bus.wr_strobe = strobe;
   assign bus.busy      = busy_reg;

endmodule
`default_nettype wire

// File: tb/tb_i2c_segment_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_i2c_segment_target                                        |
// | Purpose   : Self-checking bench: bit-banged I2C master with a wired-AND  |
// |             SDA, table of write transactions plus hand sequences for     |
// |             repeated START and readback (I2C_SEG_READBACK_EN aware).     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_i2c_segment_target;

   localparam int Q = 8;   // clk cycles per quarter SCL period

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   strobe_total = 0;

   i2c_segment_target_if bus();
   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_segment_target #(
      .ADDR(7'h2A), .SYNC_STAGES(2), .RESET_PATTERN(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.wr_strobe === 1'b1) strobe_total++;

   typedef struct packed {
      logic [7:0] addr_byte;
      logic [7:0] d0;
      logic [7:0] d1;
      int         ndata;
      logic       exp_ack;
      logic [7:0] exp_seg;
      int         exp_strobes;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      sda_m = b;    wq(Q);
      scl_m = 1'b1; wq(Q);
      seen  = bus.sda_in;
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(nack, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rd;
      int         st0;
      logic       exp_rd_ack;

      //                addr   d0     d1     n  ack  seg    strobes
      vecs[0] = '{8'h54, 8'hA5, 8'h00, 1, 1'b1, 8'hA5, 1};
      vecs[1] = '{8'h56, 8'hFF, 8'h00, 1, 1'b0, 8'hA5, 0};
      vecs[2] = '{8'h54, 8'h3C, 8'h81, 2, 1'b1, 8'h81, 2};
      vecs[3] = '{8'h14, 8'h11, 8'h00, 1, 1'b0, 8'h81, 0};
      vecs[4] = '{8'h54, 8'h7F, 8'h80, 2, 1'b1, 8'h80, 2};

      rst = 1'b1;
      wq(2);
      check("reset_seg",    32'(bus.seg_out),   32'h00);
      check("reset_sda_oe", 32'(bus.sda_oe),    32'h0);
      check("reset_busy",   32'(bus.busy),      32'h0);
      check("reset_strobe", 32'(bus.wr_strobe), 32'h0);
      rst = 1'b0;
      wq(4);

      for (int v = 0; v < 5; v++) begin
         st0 = strobe_total;
         i2c_start();
         check($sformatf("v%0d_busy_start", v), 32'(bus.busy), 32'h1);
         write_byte(vecs[v].addr_byte, ack);
         check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         check($sformatf("v%0d_busy_addr", v), 32'(bus.busy), 32'(vecs[v].exp_ack));
         write_byte(vecs[v].d0, ack);
         check($sformatf("v%0d_d0_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         if (vecs[v].ndata > 1) begin
            write_byte(vecs[v].d1, ack);
            check($sformatf("v%0d_d1_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         end
         i2c_stop();
         wq(4);
         check($sformatf("v%0d_seg", v),     32'(bus.seg_out), 32'(vecs[v].exp_seg));
         check($sformatf("v%0d_strobes", v), 32'(strobe_total - st0), 32'(vecs[v].exp_strobes));
         check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'h0);
         check($sformatf("v%0d_sda_oe", v),  32'(bus.sda_oe), 32'h0);
      end

      // Partial byte aborted by a repeated START, then a full write.
      st0 = strobe_total;
      i2c_start();
      write_byte(8'h54, ack);
      check("rs_addr_ack", 32'(ack), 32'h1);
      for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
      check("rs_busy", 32'(bus.busy), 32'h1);
      check("rs_seg_hold", 32'(bus.seg_out), 32'h80);
      write_byte(8'h54, ack);
      check("rs_addr2_ack", 32'(ack), 32'h1);
      write_byte(8'h06, ack);
      check("rs_data_ack", 32'(ack), 32'h1);
      i2c_stop();
      wq(4);
      check("rs_seg", 32'(bus.seg_out), 32'h06);
      check("rs_strobes", 32'(strobe_total - st0), 32'd1);

      // Readback of the stored pattern.
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h5B, ack);
      i2c_stop();
      wq(4);
      check("rb_seg_written", 32'(bus.seg_out), 32'h5B);
`ifdef I2C_SEG_READBACK_EN
      exp_rd_ack = 1'b1;
`else
      exp_rd_ack = 1'b0;
`endif
      i2c_start();
      write_byte(8'h55, ack);
      check("rb_addr_ack", 32'(ack), 32'(exp_rd_ack));
      if (ack) begin
         read_byte(1'b1, rd);
         check("rb_data", 32'(rd), 32'h5B);
         check("rb_busy_after_nack", 32'(bus.busy), 32'h0);
      end
      i2c_stop();
      wq(4);
      check("rb_seg_kept", 32'(bus.seg_out), 32'h5B);
      check("rb_busy_end", 32'(bus.busy), 32'h0);
      check("rb_sda_oe", 32'(bus.sda_oe), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
